// File: rtl/audio_pkg.sv
// Shared defaults and state encoding for the I2S audio DAC transmitter.
package audio_pkg;

   localparam int DATA_WIDTH_DEF = 24;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam logic [4:0] BIT_CNT_MAX = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } tx_state_e;

   function automatic logic [4:0] sat_inc5(input logic [4:0] v);
      return (v == BIT_CNT_MAX) ? v : v + 5'd1;
   endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Stereo-pair sample buffer; DEPTH must be a power of two so pointers wrap naturally.
module dac_sample_fifo
   import audio_pkg::*;
#(
   parameter int WIDTH = 2 * DATA_WIDTH_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;
   logic             push_acc_s;
   logic             pop_acc_s;

   assign full       = (level_r == LW'(DEPTH));
   assign empty      = (level_r == {LW{1'b0}});
   assign push_acc_s = push & ~full;
   assign pop_acc_s  = pop & ~empty;
   assign pop_data   = mem_r[rd_ptr_r];
   assign level      = level_r;

   // Sample storage carries no reset; only occupied slots are ever read.
   always_ff @(posedge clk) begin
      if (push_acc_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
      end else begin
         if (push_acc_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_acc_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_acc_s, pop_acc_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/audio_dac_tx.sv
// I2S transmitter: buffers stereo pairs and shifts them out on the codec bit clock.
// Optional feature macro: AUDIO_DAC_TX_UNDERRUN_CNT_EN enables the saturating underrun counter.
module audio_dac_tx
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                        CLOCK_50,
   input  logic                        reset,
   input  logic                        write,
   input  logic [DATA_WIDTH-1:0]       writedata_left,
   input  logic [DATA_WIDTH-1:0]       writedata_right,
   output logic                        write_ready,
   input  logic                        AUD_BCLK,
   input  logic                        AUD_DACLRCK,
   output logic                        AUD_DACDAT,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        underrun,
   output logic [15:0]                 underrun_count
);

   localparam logic [4:0] DW_CNT = 5'(DATA_WIDTH);

   logic                      bclk_s1_r, bclk_s2_r, bclk_d_r;
   logic                      lrck_s1_r, lrck_s2_r, lrck_prev_r;
   logic                      fall_s, chan_start_s;
   tx_state_e                 state_r, state_next_s;
   logic                      enter_left_s, enter_right_s;
   logic                      fifo_full_s, fifo_empty_s;
   logic [2*DATA_WIDTH-1:0]   pop_data_s, frame_r;
   logic [DATA_WIDTH-1:0]     chan_smp_s;
   logic [4:0]                bit_cnt_r;
   logic                      dacdat_r, underrun_r, underrun_s;

   function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] smp, input logic [4:0] cnt);
      logic b;
      b = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (5'(DATA_WIDTH - 1 - i) == cnt) begin
            b = smp[i];
         end
      end
      return b;
   endfunction

   dac_sample_fifo #(
      .WIDTH (2 * DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (CLOCK_50),
      .reset     (reset),
      .push      (write),
      .push_data ({writedata_left, writedata_right}),
      .pop       (enter_left_s),
      .pop_data  (pop_data_s),
      .level     (fifo_level),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   assign write_ready  = ~fifo_full_s;
   assign fall_s       = bclk_d_r & ~bclk_s2_r;
   assign chan_start_s = fall_s & (lrck_s2_r != lrck_prev_r);
   assign underrun_s   = enter_left_s & fifo_empty_s;
   assign chan_smp_s   = (state_r == ST_RIGHT) ? frame_r[DATA_WIDTH-1:0]
                                               : frame_r[2*DATA_WIDTH-1:DATA_WIDTH];
   assign AUD_DACDAT   = dacdat_r;
   assign underrun     = underrun_r;

   // Codec clock synchronizers; LRCK is only looked at on bit-clock falls.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         bclk_s1_r   <= 1'b0;
         bclk_s2_r   <= 1'b0;
         bclk_d_r    <= 1'b0;
         lrck_s1_r   <= 1'b0;
         lrck_s2_r   <= 1'b0;
         lrck_prev_r <= 1'b0;
      end else begin
         bclk_s1_r <= AUD_BCLK;
         bclk_s2_r <= bclk_s1_r;
         bclk_d_r  <= bclk_s2_r;
         lrck_s1_r <= AUD_DACLRCK;
         lrck_s2_r <= lrck_s1_r;
         if (fall_s) begin
            lrck_prev_r <= lrck_s2_r;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   always_comb begin
      state_next_s  = state_r;
      enter_left_s  = 1'b0;
      enter_right_s = 1'b0;
      if (chan_start_s) begin
         case (state_r)
            ST_IDLE, ST_RIGHT: begin
               if (!lrck_s2_r) begin
                  state_next_s = ST_LEFT;
                  enter_left_s = 1'b1;
               end else begin
                  state_next_s = state_r;
               end
            end
            ST_LEFT: begin
               if (lrck_s2_r) begin
                  state_next_s  = ST_RIGHT;
                  enter_right_s = 1'b1;
               end else begin
                  state_next_s = state_r;
               end
            end
            default: state_next_s = ST_IDLE;
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // Frame load and serial output; the first fall of each channel is the I2S delay slot.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         frame_r    <= {(2*DATA_WIDTH){1'b0}};
         bit_cnt_r  <= 5'd0;
         dacdat_r   <= 1'b0;
         underrun_r <= 1'b0;
      end else begin
         underrun_r <= underrun_s;
         if (enter_left_s) begin
            frame_r <= fifo_empty_s ? {(2*DATA_WIDTH){1'b0}} : pop_data_s;
         end
         if (fall_s) begin
            if (chan_start_s) begin
               bit_cnt_r <= 5'd0;
               dacdat_r  <= 1'b0;
            end else begin
               bit_cnt_r <= sat_inc5(bit_cnt_r);
               if ((state_r != ST_IDLE) && (bit_cnt_r < DW_CNT)) begin
                  dacdat_r <= pick_bit(chan_smp_s, bit_cnt_r);
               end else begin
                  dacdat_r <= 1'b0;
               end
            end
         end
      end
   end

`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
   logic [15:0] urun_cnt_r;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         urun_cnt_r <= 16'h0000;
      end else if (underrun_s && (urun_cnt_r != 16'hFFFF)) begin
         urun_cnt_r <= urun_cnt_r + 16'h0001;
      end else begin
         urun_cnt_r <= urun_cnt_r;
      end
   end

   assign underrun_count = urun_cnt_r;
`else
   assign underrun_count = 16'h0000;
`endif

endmodule
